// File: rtl/tft_display_axil_pkg.sv
// Shared constants, state types and byte-merge helper for the
// tft_display AXI4-Lite register block.
package tft_display_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] REG_CTRL0   = 3'd0;
    localparam logic [2:0] REG_CTRL1   = 3'd1;
    localparam logic [2:0] REG_CTRL2   = 3'd2;
    localparam logic [2:0] REG_CTRL3   = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_VERSION = 3'd5;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COLLECT,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/tft_display_axil_regs.sv
// AXI4-Lite register file for the tft_display core: four RW control
// words, live status, version, one outstanding transaction per direction.
module tft_display_axil_regs
    import tft_display_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] C_VERSION          = 32'h0001_0000
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [31:0]                     status_i,
    output logic [31:0]                     reg0_o,
    output logic [31:0]                     reg1_o,
    output logic [31:0]                     reg2_o,
    output logic [31:0]                     reg3_o,
    output logic [3:0]                      reg_wr_stb_o
);

    wstate_e     wstate_q, wstate_d;
    rstate_e     rstate_q, rstate_d;
    logic        aw_full_q, aw_full_d;
    logic        w_full_q, w_full_d;
    logic [2:0]  awidx_q, awidx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic [3:0]  stb_q, stb_d;

    logic        aw_hs, w_hs, ar_hs;
    logic        have_aw, have_w;
    logic [2:0]  widx, ridx;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        unused_ok;

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;
    assign ar_hs = S_AXI_ARVALID & arready_q;

    // Commit on the edge that completes the pair, using the buffered or live side.
    assign have_aw = aw_full_q | aw_hs;
    assign have_w  = w_full_q | w_hs;
    assign widx    = aw_full_q ? awidx_q : S_AXI_AWADDR[4:2];
    assign wd      = w_full_q ? wdata_q : S_AXI_WDATA[31:0];
    assign ws      = w_full_q ? wstrb_q : S_AXI_WSTRB[3:0];
    assign ridx    = S_AXI_ARADDR[4:2];

    always_comb begin
        wstate_d  = wstate_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        stb_d     = '0;
        unique case (wstate_q)
            W_IDLE, W_COLLECT: begin
                if (aw_hs) begin
                    aw_full_d = 1'b1;
                    awidx_d   = S_AXI_AWADDR[4:2];
                end
                if (w_hs) begin
                    w_full_d = 1'b1;
                    wdata_d  = S_AXI_WDATA[31:0];
                    wstrb_d  = S_AXI_WSTRB[3:0];
                end
                if (have_aw && have_w) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    wstate_d  = W_RESP;
                    if (widx <= REG_CTRL3) begin
                        regs_d[widx[1:0]] = merge_bytes(regs_q[widx[1:0]], wd, ws);
                        stb_d[widx[1:0]]  = 1'b1;
                        bresp_d           = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else if (aw_hs || w_hs) begin
                    wstate_d = W_COLLECT;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        awready_d = ~aw_full_d & (wstate_d != W_RESP);
        wready_d  = ~w_full_d & (wstate_d != W_RESP);
    end

    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                    rresp_d  = RESP_OKAY;
                    case (ridx)
                        REG_CTRL0, REG_CTRL1,
                        REG_CTRL2, REG_CTRL3: rdata_d = regs_q[ridx[1:0]];
                        REG_STATUS:           rdata_d = status_i;
                        REG_VERSION:          rdata_d = C_VERSION;
                        default: begin
                            rdata_d = '0;
                            rresp_d = RESP_SLVERR;
                        end
                    endcase
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            regs_q    <= '{default: '0};
            stb_q     <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
            stb_q     <= stb_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg0_o        = regs_q[0];
    assign reg1_o        = regs_q[1];
    assign reg2_o        = regs_q[2];
    assign reg3_o        = regs_q[3];
    assign reg_wr_stb_o  = stb_q;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_tft_display_axil_regs.sv
// Directed bench for tft_display_axil_regs with a response scoreboard
// and an independent register model.
module tb_tft_display_axil_regs;

    logic        aclk = 1'b0;
    logic        areset;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] status;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  stb;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m [4];
    logic [1:0]  q_bresp [$];
    logic [3:0]  q_stb [$];
    logic [31:0] q_rdata [$];
    logic [1:0]  q_rresp [$];

    always #5 aclk = ~aclk;

    tft_display_axil_regs dut (
        .S_AXI_ACLK    (aclk),
        .S_AXI_ARESET  (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .status_i      (status),
        .reg0_o        (reg0),
        .reg1_o        (reg1),
        .reg2_o        (reg2),
        .reg3_o        (reg3),
        .reg_wr_stb_o  (stb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [2:0] idx;
        idx = a[4:2];
        if (idx < 3'd4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m[idx[1:0]][8*b +: 8] = d[8*b +: 8];
            q_bresp.push_back(2'b00);
            q_stb.push_back(4'b0001 << idx[1:0]);
        end else begin
            q_bresp.push_back(2'b10);
            q_stb.push_back(4'b0000);
        end
    endfunction

    task automatic check_b(input string tag);
        chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        chk({tag, "_bresp"}, {30'd0, bresp}, {30'd0, q_bresp.pop_front()});
        chk({tag, "_stb"}, {28'd0, stb}, {28'd0, q_stb.pop_front()});
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_reg0"}, reg0, m[0]);
        chk({tag, "_reg1"}, reg1, m[1]);
        chk({tag, "_reg2"}, reg2, m[2]);
        chk({tag, "_reg3"}, reg3, m[3]);
    endtask

    task automatic axi_write(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        bit awd, wd;
        int n;
        model_write(a, d, s);
        @(negedge aclk);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        bready = 1'b1;
        awd = 0; wd = 0; n = 0;
        while (!(awd && wd) && n < 20) begin
            if (awvalid && awready) awd = 1;
            if (wvalid && wready) wd = 1;
            @(negedge aclk);
            n++;
            if (awd) awvalid = 1'b0;
            if (wd) wvalid = 1'b0;
        end
        chk({tag, "_hs"}, {30'd0, awd, wd}, 32'd3);
        awvalid = 1'b0; wvalid = 1'b0;
        check_b(tag);
        @(negedge aclk);
    endtask

    task automatic axi_read(input string tag, input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        q_rdata.push_back(ed);
        q_rresp.push_back(er);
        @(negedge aclk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_arready"}, {31'd0, arready}, 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk({tag, "_rdata"}, rdata, q_rdata.pop_front());
        chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, q_rresp.pop_front()});
        @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ed;
        logic [1:0]  eb, er;
        logic [3:0]  es;
        int n;
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        status = 32'hCAFE_0004;
        for (int i = 0; i < 4; i++) m[i] = '0;

        repeat (2) @(negedge aclk);
        chk("rst_handshake", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
        chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stb", {28'd0, stb}, 32'd0);
        check_regs("rst");
        areset = 1'b0;

        axi_write("w0", 5'h00, 32'd1, 4'hF);
        axi_write("w1", 5'h04, 32'd2, 4'hF);
        axi_write("w2", 5'h08, 32'd3, 4'hF);
        axi_write("w3", 5'h0C, 32'd4, 4'hF);
        axi_read("r0", 5'h00, 32'd1, 2'b00);
        axi_read("r1", 5'h04, 32'd2, 2'b00);
        axi_read("r2", 5'h08, 32'd3, 2'b00);
        axi_read("r3", 5'h0C, 32'd4, 2'b00);
        check_regs("seq");

        axi_write("wff", 5'h00, 32'hFFFF_FFFF, 4'hF);
        axi_write("wpart", 5'h00, 32'h1234_5678, 4'b0101);
        chk("merge_reg0", reg0, 32'hFF34_FF78);
        axi_write("wnostrb", 5'h0C, 32'hDEAD_BEEF, 4'b0000);
        chk("nostrb_reg3", reg3, m[3]);

        // Data leads address by three cycles.
        model_write(5'h08, 32'hA5A5_0003, 4'hF);
        @(negedge aclk);
        wdata = 32'hA5A5_0003; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        chk("wlead_wready", {31'd0, wready}, 32'd1);
        @(negedge aclk);
        wvalid = 1'b0;
        chk("wlead_wready_drop", {31'd0, wready}, 32'd0);
        repeat (2) @(negedge aclk);
        chk("wlead_wready_hold", {31'd0, wready}, 32'd0);
        chk("wlead_no_b", {31'd0, bvalid}, 32'd0);
        awaddr = 5'h08; awvalid = 1'b1;
        chk("wlead_awready", {31'd0, awready}, 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        check_b("wlead");
        chk("wlead_reg2", reg2, 32'hA5A5_0003);
        @(negedge aclk);

        axi_write("wstat", 5'h10, 32'h1111_1111, 4'hF);
        axi_write("wrsv", 5'h18, 32'h2222_2222, 4'hF);
        check_regs("ro");
        axi_read("rstat", 5'h10, 32'hCAFE_0004, 2'b00);
        axi_read("rver", 5'h14, 32'h0001_0000, 2'b00);
        axi_read("rrsv", 5'h1C, 32'h0000_0000, 2'b10);

        // Same-word read and write on one edge, then backpressure.
        q_rdata.push_back(m[1]);
        q_rresp.push_back(2'b00);
        model_write(5'h04, 32'hBEEF_0002, 4'hF);
        @(negedge aclk);
        n = 0;
        while (!(awready && wready && arready) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("bp_ready", {29'd0, awready, wready, arready}, 32'd7);
        awaddr = 5'h04; awvalid = 1'b1;
        wdata = 32'hBEEF_0002; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        eb = q_bresp.pop_front();
        es = q_stb.pop_front();
        ed = q_rdata.pop_front();
        er = q_rresp.pop_front();
        chk("bp_stb", {28'd0, stb}, {28'd0, es});
        chk("bp_rdata_prewrite", rdata, ed);
        repeat (5) begin
            chk("bp_valids", {30'd0, bvalid, rvalid}, 32'd3);
            chk("bp_resps", {28'd0, bresp, rresp}, {28'd0, eb, er});
            chk("bp_rdata", rdata, ed);
            chk("bp_readies", {29'd0, awready, wready, arready}, 32'd0);
            @(negedge aclk);
        end
        chk("bp_stb_clear", {28'd0, stb}, 32'd0);
        chk("bp_reg1", reg1, m[1]);
        bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        chk("bp_release_valids", {30'd0, bvalid, rvalid}, 32'd0);
        chk("bp_release_ready", {29'd0, awready, wready, arready}, 32'd7);

        // Reset between address and data drops the write.
        @(negedge aclk);
        awaddr = 5'h00; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("rmid_awready", {31'd0, awready}, 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        for (int i = 0; i < 4; i++) m[i] = '0;
        chk("rmid_stb", {28'd0, stb}, 32'd0);
        repeat (3) begin
            @(negedge aclk);
            chk("rmid_no_b", {31'd0, bvalid}, 32'd0);
        end
        check_regs("rmid");
        axi_read("rmid_r0", 5'h00, 32'd0, 2'b00);
        axi_read("rmid_r1", 5'h04, 32'd0, 2'b00);
        axi_read("rmid_r2", 5'h08, 32'd0, 2'b00);
        axi_read("rmid_r3", 5'h0C, 32'd0, 2'b00);
        axi_write("rmid_w", 5'h00, 32'h600D_0000, 4'hF);
        check_regs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tft_display_axil_regs.md
Name: tft_display_axil_regs

Overview:
- AXI4-Lite slave (responder) register file for the tft_display IP; it is the endpoint that the AXI VIP master bench drives with AXI4LITE_WRITE_BURST and AXI4LITE_READ_BURST.
- Provides four read/write control registers, one read-only status register and one read-only version register.
- Emits one-cycle per-register write strobes to the display core.
- Fully registered handshakes; one outstanding transaction per direction.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots.
- C_VERSION, 32'h0001_0000, value returned at word 5.

Ports:
- S_AXI_ACLK  in  1  single clock
- S_AXI_ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  5  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
- S_AXI_ARADDR  in  5  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
- status_i  in  32  live core status, read at word 4
- reg0_o..reg3_o  out  32 each  control register contents
- reg_wr_stb_o  out  4  one-hot pulse per RW register on write commit

Behaviour:
- Reset (S_AXI_ARESET high at a clock edge): all READY and VALID outputs 0, BRESP and RRESP 0, RDATA 0, reg0..reg3 0, reg_wr_stb_o 0. Any in-flight transaction is dropped with no response.
- Decode uses word index = addr[4:2]; addr[1:0] are ignored.
  - Words 0-3: RW.
  - Word 4: status_i, RO.
  - Word 5: C_VERSION, RO.
  - Words 6-7: reserved.
- Write path, states W_IDLE, W_COLLECT, W_RESP:
  - AWREADY is high while no address is buffered and the path is not in W_RESP. WREADY behaves the same way for data.
  - AW and W may arrive in the same cycle or in either order. Each is captured on its own handshake and its READY drops after capture.
  - When both are buffered: commit at the next edge, assert BVALID, enter W_RESP.
  - Commit updates only the bytes selected by WSTRB. reg_wr_stb_o[idx] is high for exactly that one cycle.
  - Latency: BVALID rises 1 cycle after the later of the AW and W handshakes.
  - BRESP is OKAY (00) for words 0-3 and SLVERR (10) for words 4-7. Those writes change no state and raise no strobe.
  - BVALID and BRESP hold until BREADY. Return to W_IDLE on the BVALID&BREADY edge; AWREADY and WREADY are high again in the following cycle.
  - WSTRB = 0 to words 0-3: OKAY response, no data change, strobe still pulses.
- Read path, states R_IDLE, R_DATA:
  - ARREADY is high in R_IDLE only.
  - On the AR handshake: RDATA and RRESP are registered and RVALID is asserted at the next edge (1-cycle latency).
  - Words 0-5 return OKAY. Words 6-7 return RDATA = 0 with RRESP = SLVERR.
  - RDATA, RRESP and RVALID hold stable until RREADY. Then return to R_IDLE.
- Simultaneous read and write to the same word: a read whose data is registered on the same edge as the write commit returns the pre-write value.
- Read and write paths are independent and may overlap freely.
- status_i is sampled at the edge that registers RDATA; no synchroniser is included, so status_i must already be in the S_AXI_ACLK domain.

Decomposition:
- Package tft_display_axil_pkg holds:
  - Response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - Word index constants REG_CTRL0..REG_CTRL3, REG_STATUS = 4, REG_VERSION = 5.
  - Write and read state enums.
- Single module; no sub-module. The byte-strobe merge is a package function, not a sub-module.

Test Plan:
- Sequential writes of 1, 2, 3, 4 to addresses 0x0, 0x4, 0x8, 0xC, then reads of the same addresses → all BRESP = 00; reads return 1, 2, 3, 4 with RRESP = 00; reg_wr_stb_o pulses 0001, 0010, 0100, 1000.
- Write 0xFFFF_FFFF to 0x0, then write 0x1234_5678 with WSTRB = 0101 → reg0_o = 0xFF34_FF78.
- W handshake presented 3 cycles before AW to 0x8 → WREADY drops after capture; BVALID rises 1 cycle after the AW handshake; reg2 updated.
- Write to 0x10 and 0x18; read 0x14 and 0x1C → BRESP = 10 on both writes; read of 0x14 returns 0x0001_0000 with OKAY; read of 0x1C returns 0 with RRESP = 10; no strobes.
- Hold BREADY and RREADY low for 5 cycles → BVALID, RVALID and data stay stable; AWREADY, WREADY and ARREADY stay low until the response is accepted.
- Assert S_AXI_ARESET for 1 cycle after AW is accepted but before W → no BVALID; reg0..reg3 read back 0; a new write then completes normally.
